mem_port_arbiter: RTL and testbench

- Shares the single unified memory of the multi-cycle CPU between two requesters: port 0 = CPU memory interface (instruction fetch and load/store), port 1 = loader/debug DMA.
- Per-port request/ack handshake; one transaction in flight at a time.
- Converts each access size to memory byte enables. Replicates write data across the byte lanes and right-aligns read data.
- Sits between the CPU control/datapath and the memory model; the CPU stalls its FSM until ack.

---
 rtl/mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified memory: size/alignment checks, lane handling, req/ack handshake.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic [31:0]           p0_rdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic [31:0]           p1_rdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  win_q, win_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  err_q, err_d;
  logic [31:0]           rd_q, rd_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                  p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic                  p0_err_q, p0_err_d, p1_err_q, p1_err_d;

  logic                  win_c;
  logic                  sel_we;
  logic [1:0]            sel_size;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            be_c;
  logic                  err_c;
  logic [31:0]           wdata_c;
  logic [31:0]           rd_shift;
  logic [31:0]           rd_c;

`ifdef MEMARB_RR_EN
  logic rr_q, rr_d;
  // Pointer only matters on contention; a lone requester always wins.
  assign win_c = (p0_req & p1_req) ? rr_q : ~p0_req;
`else
  assign win_c = ~p0_req;
`endif

  assign sel_we    = win_c ? p1_we    : p0_we;
  assign sel_size  = win_c ? p1_size  : p0_size;
  assign sel_addr  = win_c ? p1_addr  : p0_addr;
  assign sel_wdata = win_c ? p1_wdata : p0_wdata;

  always_comb begin
    be_c    = 4'b0000;
    err_c   = 1'b0;
    wdata_c = sel_wdata;
    case (sel_size)
      2'b00: begin
        be_c  = 4'b1111;
        err_c = |sel_addr[1:0];
      end
      2'b01: begin
        be_c    = sel_addr[1] ? 4'b1100 : 4'b0011;
        err_c   = sel_addr[0];
        wdata_c = {2{sel_wdata[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b0001 << sel_addr[1:0];
        wdata_c = {4{sel_wdata[7:0]}};
      end
      default: err_c = 1'b1;
    endcase
  end

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   rd_c = rd_shift;
      2'b01:   rd_c = {16'h0000, rd_shift[15:0]};
      2'b10:   rd_c = {24'h000000, rd_shift[7:0]};
      default: rd_c = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    size_d      = size_q;
    off_d       = off_q;
    err_d       = err_q;
    rd_d        = rd_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
`ifdef MEMARB_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          win_d  = win_c;
          size_d = sel_size;
          off_d  = sel_addr[1:0];
          err_d  = err_c;
          rd_d   = 32'h0000_0000;
`ifdef MEMARB_RR_EN
          rr_d   = ~win_c;
`endif
          if (err_c) begin
            state_d = S_RESP;
          end else begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!mem_we_q) rd_d = rd_c;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (win_q) begin
          p1_ack_d   = 1'b1;
          p1_err_d   = err_q;
          p1_rdata_d = rd_q;
        end else begin
          p0_ack_d   = 1'b1;
          p0_err_d   = err_q;
          p0_rdata_d = rd_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      err_q       <= 1'b0;
      rd_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      size_q      <= size_d;
      off_q       <= off_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
    end
  end

`ifdef MEMARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow MEMARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [1:0]    p0_size, p1_size;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic          mem_en, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_en"},    32'(mem_en),    32'd0);
    chk({tag, " mem_we"},    32'(mem_we),    32'd0);
    chk({tag, " mem_addr"},  mem_addr,       32'd0);
    chk({tag, " mem_be"},    32'(mem_be),    32'd0);
    chk({tag, " mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, " p0_rdata"},  p0_rdata,       32'd0);
    chk({tag, " p1_rdata"},  p1_rdata,       32'd0);
    chk({tag, " acks"},      {30'd0, p1_ack, p0_ack}, 32'd0);
    chk({tag, " errs"},      {30'd0, p1_err, p0_err}, 32'd0);
  endtask

  initial begin : stim
    logic [AW-1:0] hold_addr;
    logic [3:0]    hold_be;
    logic [31:0]   hold_wdata;
    logic [3:0]    exp_win;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
    p0_req = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
`ifdef MEMARB_RR_EN
    exp_win = 4'b1010;
`else
    exp_win = 4'b0000;
`endif

    // reset and idle
    tick(); tick();
    chk_all_zero("rst");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle mem_en", 32'(mem_en), 32'd0);
    end
    chk_all_zero("idle");

    // p0 word write 0x10
    p0_req = 1; p0_we = 1; p0_size = 2'b00; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    tick();
    chk("ww mem_en", 32'(mem_en), 32'd1);
    chk("ww mem_we", 32'(mem_we), 32'd1);
    chk("ww mem_be", 32'(mem_be), 32'hF);
    chk("ww mem_addr", mem_addr, 32'h10);
    chk("ww mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("ww early ack", 32'(p0_ack), 32'd0);
    tick();
    chk("ww mem_en off", 32'(mem_en), 32'd0);
    chk("ww ack not yet", 32'(p0_ack), 32'd0);
    tick();
    chk("ww p0_ack", 32'(p0_ack), 32'd1);
    chk("ww p0_err", 32'(p0_err), 32'd0);
    chk("ww p1_ack", 32'(p1_ack), 32'd0);
    p0_req = 0;
    tick();
    chk("ww ack pulse", 32'(p0_ack), 32'd0);

    // p0 word read 0x10
    p0_req = 1; p0_we = 0; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("wr mem_en", 32'(mem_en), 32'd1);
    chk("wr mem_we", 32'(mem_we), 32'd0);
    tick(); tick();
    chk("wr p0_ack", 32'(p0_ack), 32'd1);
    chk("wr p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("wr p0_err", 32'(p0_err), 32'd0);
    p0_req = 0;
    tick();

    // p1 byte write 0xA5 at 0x13
    p1_req = 1; p1_we = 1; p1_size = 2'b10; p1_addr = 32'h13; p1_wdata = 32'h000000A5;
    tick();
    chk("bw mem_be", 32'(mem_be), 32'h8);
    chk("bw mem_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("bw mem_addr", mem_addr, 32'h10);
    tick(); tick();
    chk("bw p1_ack", 32'(p1_ack), 32'd1);
    chk("bw p0_ack", 32'(p0_ack), 32'd0);
    p1_req = 0;
    tick();

    // p1 half read at 0x12
    p1_req = 1; p1_we = 0; p1_size = 2'b01; p1_addr = 32'h12; mem_rdata = 32'h12345678;
    tick();
    chk("hr mem_be", 32'(mem_be), 32'hC);
    chk("hr mem_we", 32'(mem_we), 32'd0);
    tick(); tick();
    chk("hr p1_ack", 32'(p1_ack), 32'd1);
    chk("hr p1_rdata", p1_rdata, 32'h00001234);
    chk("hr p0_rdata held", p0_rdata, 32'hDEADBEEF);
    p1_req = 0;
    tick();

    // misaligned word read at 0x06, then reserved size at 0x00
    for (int k = 0; k < 2; k++) begin
      p0_req = 1; p0_we = 0;
      p0_size = (k == 0) ? 2'b00 : 2'b11;
      p0_addr = (k == 0) ? 32'h06 : 32'h00;
      tick();
      chk("err no mem_en", 32'(mem_en), 32'd0);
      chk("err early ack", 32'(p0_ack), 32'd0);
      tick();
      chk("err no mem_en 2", 32'(mem_en), 32'd0);
      chk("err p0_ack", 32'(p0_ack), 32'd1);
      chk("err p0_err", 32'(p0_err), 32'd1);
      p0_req = 0;
      tick();
      chk("err ack pulse", {30'd0, p0_ack, p0_err}, 32'd0);
    end

    // contention after a fresh reset so the pointer starts at port 0
    rst = 1; tick(); rst = 0;
    mem_ready = 0;
    p0_req = 1; p0_we = 1; p0_size = 2'b00; p0_addr = 32'h20; p0_wdata = 32'h11111111;
    p1_req = 1; p1_we = 1; p1_size = 2'b00; p1_addr = 32'h30; p1_wdata = 32'h22222222;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("ct mem_en", 32'(mem_en), 32'd1);
      chk("ct grant addr", mem_addr, exp_win[t] ? 32'h30 : 32'h20);
      hold_addr = mem_addr; hold_be = mem_be; hold_wdata = mem_wdata;
      for (int w = 0; w < 3; w++) begin
        tick();
        chk("ct hold en", 32'(mem_en), 32'd1);
        chk("ct hold addr", mem_addr, hold_addr);
        chk("ct hold be", 32'(mem_be), 32'(hold_be));
        chk("ct hold wdata", mem_wdata, hold_wdata);
        chk("ct no ack", {30'd0, p1_ack, p0_ack}, 32'd0);
      end
      mem_ready = 1;
      tick();
      mem_ready = 0;
      chk("ct mem_en off", 32'(mem_en), 32'd0);
      tick();
      chk("ct acks", {30'd0, p1_ack, p0_ack}, exp_win[t] ? 32'd2 : 32'd1);
    end
    p0_req = 0; p1_req = 0;
    tick(); tick();

    // reset while in ACCESS
    p1_req = 1; p1_we = 0; p1_size = 2'b00; p1_addr = 32'h40; mem_ready = 0;
    tick();
    chk("ra mem_en", 32'(mem_en), 32'd1);
    #2 rst = 1;
    #1;
    chk("ra async drop", 32'(mem_en), 32'd0);
    chk_all_zero("ra in rst");
    tick(); tick();
    chk("ra no ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    rst = 0; mem_ready = 1;
    tick();
    chk("ra reserve en", 32'(mem_en), 32'd1);
    chk("ra reserve addr", mem_addr, 32'h40);
    tick(); tick();
    chk("ra p1_ack", 32'(p1_ack), 32'd1);
    p1_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
